// File: rtl/pmu_command_scheduler.sv
// Power-management command scheduler: round-robin level arbitration, strict-priority
// mode requests, shadow-based redundancy filtering, settle guard and warmboot lockout.
module pmu_command_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_level,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   mode_req,
  input  logic                   mode_sel,
  output logic                   mode_ack,
  output logic                   change_level_flag,
  output logic [2:0]             change_level,
  output logic                   change_power_mode_flag,
  output logic                   change_power_mode,
  output logic [1:0]             dom0_level,
  output logic [1:0]             dom1_level,
  output logic                   busy,
  output logic                   locked
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_GUARD  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t             state_q;
  state_t             after_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [GW-1:0]      guard_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               mode_ack_q;
  logic               clf_q;
  logic [2:0]         cl_q;
  logic               cpmf_q;
  logic               cpm_q;
  logic [1:0]         dom0_q;
  logic [1:0]         dom1_q;
  logic               busy_q;
  logic               locked_q;

  logic [2:0]         lvl_a [NUM_REQ];
  logic [PW:0]        cand_s;
  logic               grant_found_s;
  logic [PW-1:0]      grant_idx_s;
  logic [PW-1:0]      rr_next_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic [2:0]         grant_lvl_s;
  logic               redundant_s;

  // Unpack the per-requester level fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lvl_a[i] = req_level[3*i +: 3];
    end
  end

  // Round-robin search; scanning downward leaves the nearest valid index from rr_ptr.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand_s >= (PW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (PW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (req_valid[cand_s[PW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Winner's level, one-hot ack, next pointer and redundancy against the target shadow.
  always_comb begin
    grant_lvl_s = lvl_a[grant_idx_s];
    grant_oh_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    if (grant_idx_s == PW'(NUM_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + PW'(1);
    end
    if (grant_lvl_s[2]) begin
      redundant_s = (grant_lvl_s[1:0] == dom1_q);
    end else begin
      redundant_s = (grant_lvl_s[1:0] == dom0_q);
    end
  end

  // Scheduler FSM with registered command, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      after_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      guard_q     <= '0;
      req_ready_q <= '0;
      mode_ack_q  <= 1'b0;
      clf_q       <= 1'b0;
      cl_q        <= 3'b000;
      cpmf_q      <= 1'b0;
      cpm_q       <= 1'b0;
      dom0_q      <= 2'b01;
      dom1_q      <= 2'b10;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      req_ready_q <= '0;
      mode_ack_q  <= 1'b0;
      clf_q       <= 1'b0;
      cpmf_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mode_req) begin
            state_q    <= ST_ISSUE;
            busy_q     <= 1'b1;
            cpmf_q     <= 1'b1;
            cpm_q      <= mode_sel;
            mode_ack_q <= 1'b1;
            if (mode_sel) begin
              after_q <= ST_LOCKED;
            end else begin
              after_q <= ST_GUARD;
              dom0_q  <= 2'b01;
              dom1_q  <= 2'b10;
            end
          end else if (grant_found_s) begin
            state_q     <= ST_ISSUE;
            busy_q      <= 1'b1;
            req_ready_q <= grant_oh_s;
            rr_ptr_q    <= rr_next_s;
            if (redundant_s) begin
              after_q <= ST_IDLE;
            end else begin
              after_q <= ST_GUARD;
              clf_q   <= 1'b1;
              cl_q    <= grant_lvl_s;
              if (grant_lvl_s[2]) begin
                dom1_q <= grant_lvl_s[1:0];
              end else begin
                dom0_q <= grant_lvl_s[1:0];
              end
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q  <= after_q;
          busy_q   <= (after_q != ST_IDLE);
          guard_q  <= (after_q == ST_GUARD) ? GW'(GUARD_CYCLES) : '0;
          locked_q <= (after_q == ST_LOCKED);
        end
        ST_GUARD: begin
          // Leaving on count 1 gives exactly GUARD_CYCLES cycles spent in this state.
          if (guard_q <= GW'(1)) begin
            state_q <= ST_IDLE;
            guard_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            guard_q <= guard_q - GW'(1);
          end
        end
        ST_LOCKED: begin
          busy_q   <= 1'b1;
          locked_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready              = req_ready_q;
  assign mode_ack               = mode_ack_q;
  assign change_level_flag      = clf_q;
  assign change_level           = cl_q;
  assign change_power_mode_flag = cpmf_q;
  assign change_power_mode      = cpm_q;
  assign dom0_level             = dom0_q;
  assign dom1_level             = dom1_q;
  assign busy                   = busy_q;
  assign locked                 = locked_q;
endmodule
